// File: rtl/banco_registradores_quatro.sv
// Four-entry register bank ahead of the Nrisc 4:1 operand mux: drives the mux data
// inputs and select, plus a registered (write-bypassed) copy of the selected operand.
module banco_registradores_quatro #(
    parameter int                   LARGURA     = 8,
    parameter logic [LARGURA-1:0]   VALOR_RESET = 8'h00
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               escrita_en,
    input  logic [1:0]         endereco_escrita,
    input  logic [LARGURA-1:0] dado_escrita,
    input  logic               leitura_req,
    input  logic [1:0]         endereco_leitura,
    output logic [LARGURA-1:0] reg0,
    output logic [LARGURA-1:0] reg1,
    output logic [LARGURA-1:0] reg2,
    output logic [LARGURA-1:0] reg3,
    output logic [1:0]         selecao,
    output logic [LARGURA-1:0] dado_lido,
    output logic               valido,
    output logic [7:0]         contador_escritas
);

    logic [LARGURA-1:0] reg0_r;
    logic [LARGURA-1:0] reg1_r;
    logic [LARGURA-1:0] reg2_r;
    logic [LARGURA-1:0] reg3_r;
    logic [1:0]         selecao_r;
    logic [LARGURA-1:0] dado_lido_r;
    logic               valido_r;
    logic [7:0]         contador_r;
    logic [LARGURA-1:0] lido_banco_s;
    logic [LARGURA-1:0] dado_leitura_s;

    // Select the stored operand addressed by the read port.
    always_comb begin
        lido_banco_s = reg0_r;
        case (endereco_leitura)
            2'd0:    lido_banco_s = reg0_r;
            2'd1:    lido_banco_s = reg1_r;
            2'd2:    lido_banco_s = reg2_r;
            2'd3:    lido_banco_s = reg3_r;
            default: lido_banco_s = reg0_r;
        endcase
    end

    // Same-edge write to the read address wins so the reader sees the new data.
    always_comb begin
        dado_leitura_s = lido_banco_s;
        if (escrita_en && (endereco_escrita == endereco_leitura)) begin
            dado_leitura_s = dado_escrita;
        end else begin
            dado_leitura_s = lido_banco_s;
        end
    end

    // Register storage; reset outranks any write in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            reg0_r <= VALOR_RESET;
            reg1_r <= VALOR_RESET;
            reg2_r <= VALOR_RESET;
            reg3_r <= VALOR_RESET;
        end else if (escrita_en) begin
            case (endereco_escrita)
                2'd0:    reg0_r <= dado_escrita;
                2'd1:    reg1_r <= dado_escrita;
                2'd2:    reg2_r <= dado_escrita;
                2'd3:    reg3_r <= dado_escrita;
                default: reg0_r <= reg0_r;
            endcase
        end
    end

    // Write counter, wraps naturally at 8 bits; rewriting an equal value still counts.
    always_ff @(posedge clock) begin
        if (reset) begin
            contador_r <= 8'd0;
        end else if (escrita_en) begin
            contador_r <= contador_r + 8'd1;
        end
    end

    // Read pipeline stage: select and data hold when idle, valid pulses per request.
    always_ff @(posedge clock) begin
        if (reset) begin
            selecao_r   <= 2'd0;
            dado_lido_r <= {LARGURA{1'b0}};
            valido_r    <= 1'b0;
        end else if (leitura_req) begin
            selecao_r   <= endereco_leitura;
            dado_lido_r <= dado_leitura_s;
            valido_r    <= 1'b1;
        end else begin
            valido_r    <= 1'b0;
        end
    end

    assign reg0              = reg0_r;
    assign reg1              = reg1_r;
    assign reg2              = reg2_r;
    assign reg3              = reg3_r;
    assign selecao           = selecao_r;
    assign dado_lido         = dado_lido_r;
    assign valido            = valido_r;
    assign contador_escritas = contador_r;

endmodule
